inst_prefetch_queue: RTL

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

---
 rtl/inst_prefetch_queue.sv | 110 +++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: keeps one fetch outstanding to instruction memory and
// buffers returned words with their addresses in a DEPTH-entry FIFO for the core.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  input  logic                     halt,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     imem_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic                     inst_valid,
  output logic [1:0]               fsm_state,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   req_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          issue;
  logic          push;
  logic          pop;

  // Handshakes: imem_req is a one-cycle pulse accepted unconditionally by memory, which
  // answers later with a single imem_valid cycle; the head entry transfers to the core on
  // any clock edge where inst_valid=1 and stall=0. A redirect overrides both transfers.
  assign issue      = (state == IDLE) && !halt && !redirect && (count < FULL);
  assign push       = (state == WAIT) && imem_valid && !redirect;
  assign pop        = inst_valid && !stall && !redirect;

  // Gated with rst_b so the request line is quiet for the whole reset interval.
  assign imem_req   = issue && rst_b;
  assign imem_addr  = fpc;
  assign inst_valid = (count != '0);
  assign inst       = data_mem[head];
  assign inst_pc    = pc_mem[head];
  assign fsm_state  = state;
  assign occupancy  = count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect) begin
      fpc <= {redirect_pc[31:2], 2'b00};
      // A response arriving together with the redirect is simply discarded.
      if (state == WAIT) state <= imem_valid ? IDLE : DROP;
    end else begin
      case (state)
        IDLE: if (issue) begin
          state  <= WAIT;
          req_pc <= fpc;
          fpc    <= fpc + 32'd4;
        end
        WAIT:    if (imem_valid) state <= IDLE;
        DROP:    if (imem_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Flush keeps head in place so inst/inst_pc hold their last values while empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (redirect) begin
      tail  <= head;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[tail]   <= req_pc;
        data_mem[tail] <= imem_data;
        tail           <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule
